// File: rtl/invaders_controller_pkg.sv
// -----------------------------------------------------------------------------
// invaders_controller_pkg
// Shared constants for the invader formation: grid width, formation reload
// values, landing row, game-state and march-direction encodings, and a helper
// that turns a bullet column into a one-hot column mask. sprite_drawer uses
// the same constants.
// -----------------------------------------------------------------------------
package invaders_controller_pkg;

  localparam int              COLS              = 20;
  localparam logic [4:0]      COLS_X            = 5'(COLS);
  localparam int              STEP_CYCLES_DFLT  = 6000000;
  localparam logic [COLS-1:0] INIT_ARRAY        = 20'b00101010101010101010;
  localparam logic [4:0]      INIT_LINE         = 5'd4;
  localparam logic [4:0]      LAND_LINE         = 5'd14;

  // Game state encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PLAYING   = 2'd1;
  localparam logic [1:0] ST_RELOAD    = 2'd2;
  localparam logic [1:0] ST_GAME_OVER = 2'd3;

  // March direction encoding
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef logic [COLS-1:0] inv_array_t;

  // One-hot mask for a bullet column; columns outside the grid give an empty
  // mask so they can never match a live invader.
  function automatic inv_array_t col_mask(input logic [4:0] x);
    col_mask = (x < COLS_X) ? (inv_array_t'(1) << x) : '0;
  endfunction

endpackage

// File: rtl/invaders_controller_if.sv
// -----------------------------------------------------------------------------
// invaders_controller_if
// Player bullet interface. The player (master) drives the bullet position and
// valid flag; the invaders controller (slave) answers with a one-cycle hit
// pulse and issues a one-cycle clear pulse when a game starts.
//   bullet_x      [4:0]  bullet column
//   bullet_y      [3:0]  bullet row
//   bullet_flying        bullet valid
//   hit                  bullet struck a live invader (one cycle)
//   clear                game start, player resets its state (one cycle)
// -----------------------------------------------------------------------------
interface invaders_controller_if;

  logic [4:0] bullet_x;
  logic [3:0] bullet_y;
  logic       bullet_flying;
  logic       hit;
  logic       clear;

  modport master (
    output bullet_x, bullet_y, bullet_flying,
    input  hit, clear
  );

  modport slave (
    input  bullet_x, bullet_y, bullet_flying,
    output hit, clear
  );

endinterface

// File: rtl/invaders_step_timer.sv
// -----------------------------------------------------------------------------
// invaders_step_timer
// March cadence counter. Counts enabled cycles from 0 to STEP_CYCLES-1 and
// wraps; o_step is high during the enabled cycle in which the wrap happens.
// A synchronous clear returns the count to 0 and suppresses the step.
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_en     count enable
//   i_clr    synchronous clear (has priority over i_en)
//   o_step   step strobe, combinational from the count
// -----------------------------------------------------------------------------
module invaders_step_timer #(
  parameter int STEP_CYCLES = 6000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_step
);

  localparam int            CW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_step = i_en && !i_clr && w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/invaders_controller.sv
// -----------------------------------------------------------------------------
// invaders_controller
// Owns the invader formation: sequences the game (idle, playing, wave reload,
// game over), marches the formation left/right and down at the edges, and
// answers the player's bullet with a registered one-cycle hit pulse.
//   i_clk_12MHz        system clock
//   i_reset            asynchronous active-low reset
//   i_enable           march enable (hit detection stays live when low)
//   i_start_debounced  one-cycle start pulse
//   bullet_bus         player bullet interface (slave side)
//   o_invaders_array   alive mask, bit i = invader at column i
//   o_invaders_line    formation row
//   o_game_over        high while in game over
//   o_wave_cleared     one-cycle pulse when the last invader dies
// -----------------------------------------------------------------------------
module invaders_controller
  import invaders_controller_pkg::*;
#(
  parameter int STEP_CYCLES = STEP_CYCLES_DFLT
) (
  input  logic                  i_clk_12MHz,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_start_debounced,
  invaders_controller_if.slave  bullet_bus,
  output logic [COLS-1:0]       o_invaders_array,
  output logic [4:0]            o_invaders_line,
  output logic                  o_game_over,
  output logic                  o_wave_cleared
);

  logic [1:0]      r_state, w_state_next;
  logic [COLS-1:0] r_array, w_array_next;
  logic [4:0]      r_line, w_line_next;
  logic            r_dir, w_dir_next;
  logic            r_hit_lock, w_hit_lock_next;
  logic            r_hit, r_clear, r_wave_cleared;
  logic            w_clear, w_wave_cleared;

  logic            w_playing, w_start, w_load, w_step, w_hit, w_descend;
  logic [COLS-1:0] w_hit_mask, w_cleared;
  logic [4:0]      w_line_inc;

  assign w_playing = (r_state == ST_PLAYING);
  assign w_start   = i_start_debounced &&
                     ((r_state == ST_IDLE) || (r_state == ST_GAME_OVER));
  assign w_load    = w_start || (r_state == ST_RELOAD);

  invaders_step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .i_clk   (i_clk_12MHz),
    .i_rst_n (i_reset),
    .i_en    (w_playing && i_enable),
    .i_clr   (w_load),
    .o_step  (w_step)
  );

  // Hit is judged against the pre-step formation. Rows 16..31 are below the
  // 4-bit bullet range, so line[4] set means nothing can be hit.
  assign w_hit_mask = col_mask(bullet_bus.bullet_x);
  assign w_hit      = w_playing && bullet_bus.bullet_flying && !r_hit_lock &&
                      !r_line[4] && (bullet_bus.bullet_y == r_line[3:0]) &&
                      (|(r_array & w_hit_mask));
  assign w_cleared  = w_hit ? (r_array & ~w_hit_mask) : r_array;

  // The edge test looks at the post-hit array, so killing the edge invader
  // in a step cycle turns a descent into an ordinary shift.
  assign w_descend  = (r_dir == DIR_RIGHT) ? w_cleared[COLS-1] : w_cleared[0];
  assign w_line_inc = (r_line == 5'd31) ? r_line : r_line + 5'd1;

  // Lock is held for the whole flight of a bullet that scored.
  assign w_hit_lock_next = !bullet_bus.bullet_flying ? 1'b0 :
                           (w_hit ? 1'b1 : r_hit_lock);

  always_comb begin
    w_state_next   = r_state;
    w_array_next   = r_array;
    w_line_next    = r_line;
    w_dir_next     = r_dir;
    w_clear        = 1'b0;
    w_wave_cleared = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (i_start_debounced) begin
          w_array_next = INIT_ARRAY;
          w_line_next  = INIT_LINE;
          w_dir_next   = DIR_RIGHT;
          w_clear      = 1'b1;
          w_state_next = ST_PLAYING;
        end
      end
      ST_RELOAD: begin
        w_array_next = INIT_ARRAY;
        w_line_next  = INIT_LINE;
        w_dir_next   = DIR_RIGHT;
        w_state_next = ST_PLAYING;
      end
      ST_PLAYING: begin
        w_array_next = w_cleared;
        if (w_hit && (w_cleared == '0)) begin
          // Last invader gone: no march this cycle, reload next.
          w_wave_cleared = 1'b1;
          w_state_next   = ST_RELOAD;
        end else if (w_step) begin
          if (w_descend) begin
            w_line_next = w_line_inc;
            w_dir_next  = ~r_dir;
            if (w_line_inc == LAND_LINE) begin
              w_state_next = ST_GAME_OVER;
            end
          end else if (r_dir == DIR_RIGHT) begin
            w_array_next = w_cleared << 1;
          end else begin
            w_array_next = w_cleared >> 1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_12MHz or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= ST_IDLE;
      r_array        <= '0;
      r_line         <= INIT_LINE;
      r_dir          <= DIR_RIGHT;
      r_hit_lock     <= 1'b0;
      r_hit          <= 1'b0;
      r_clear        <= 1'b0;
      r_wave_cleared <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_array        <= w_array_next;
      r_line         <= w_line_next;
      r_dir          <= w_dir_next;
      r_hit_lock     <= w_hit_lock_next;
      r_hit          <= w_hit;
      r_clear        <= w_clear;
      r_wave_cleared <= w_wave_cleared;
    end
  end

  assign o_invaders_array = r_array;
  assign o_invaders_line  = r_line;
  assign o_game_over      = (r_state == ST_GAME_OVER);
  assign o_wave_cleared   = r_wave_cleared;
  assign bullet_bus.hit   = r_hit;
  assign bullet_bus.clear = r_clear;

endmodule

// File: tb/tb_invaders_controller.sv
module tb_invaders_controller;
  import invaders_controller_pkg::*;

  localparam int STEPS = 4;
  localparam int M_IDLE = 0, M_PLAY = 1, M_RELOAD = 2, M_OVER = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        start;
  logic [19:0] arr;
  logic [4:0]  line;
  logic        go;
  logic        wc;

  always #5 clk = ~clk;

  invaders_controller_if bif();

  invaders_controller #(
    .STEP_CYCLES (STEPS)
  ) dut (
    .i_clk_12MHz       (clk),
    .i_reset           (rst_n),
    .i_enable          (enable),
    .i_start_debounced (start),
    .bullet_bus        (bif),
    .o_invaders_array  (arr),
    .o_invaders_line   (line),
    .o_game_over       (go),
    .o_wave_cleared    (wc)
  );

  // Behavioural model: formation as a bit-per-column word, row as an integer.
  int          m_state;
  logic [19:0] m_arr;
  int          m_line;
  bit          m_right;
  int          m_cnt;
  bit          m_lock, m_hit, m_clear, m_wc;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_arr = '0; m_line = 4; m_right = 1; m_cnt = 0;
    m_lock = 0; m_hit = 0; m_clear = 0; m_wc = 0;
  endtask

  task automatic model_load();
    m_arr = INIT_ARRAY; m_line = 4; m_right = 1; m_cnt = 0; m_state = M_PLAY;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_next();
    bit hit, step;
    int x, y;
    logic [19:0] a;
    hit = 0;
    m_hit = 0; m_clear = 0; m_wc = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      x = int'(bif.bullet_x);
      y = int'(bif.bullet_y);
      case (m_state)
        M_IDLE, M_OVER: if (start) begin model_load(); m_clear = 1; end
        M_RELOAD: model_load();
        default: begin
          hit = bif.bullet_flying && !m_lock && (m_line < 16) && (y == m_line) &&
                (x < 20) && (m_arr[x] == 1'b1);
          a = m_arr;
          if (hit) a[x] = 1'b0;
          step = 0;
          if (enable) begin
            step  = (m_cnt == STEPS - 1);
            m_cnt = (m_cnt + 1) % STEPS;
          end
          m_hit = hit;
          if (hit && a == 0) begin
            m_wc = 1; m_state = M_RELOAD;
          end else if (step) begin
            if (m_right ? a[19] : a[0]) begin
              m_right = !m_right;
              if (m_line < 31) m_line++;
              if (m_line == 14) m_state = M_OVER;
            end else begin
              a = m_right ? (a << 1) : (a >> 1);
            end
          end
          m_arr = a;
        end
      endcase
      if (!bif.bullet_flying) m_lock = 0;
      else if (hit) m_lock = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_next();
    #1;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("array", 32'(arr), 32'(m_arr));
      check("line", 32'(line), 32'(m_line));
      check("hit", 32'(bif.hit), 32'(m_hit));
      check("clear", 32'(bif.clear), 32'(m_clear));
      check("game_over", 32'(go), 32'(m_state == M_OVER));
      check("wave_cleared", 32'(wc), 32'(m_wc));
    end
  end

  initial begin
    int hits, cyc, c;
    bit done, last;
    logic [19:0] snap;

    rst_n = 1'b0; enable = 1'b0; start = 1'b0;
    bif.bullet_x = '0; bif.bullet_y = '0; bif.bullet_flying = 1'b0;
    model_reset();
    #1;
    chk_en = 1;
    repeat (3) tick();
    check("rst_array", 32'(arr), 32'h0);
    check("rst_line", 32'(line), 32'd4);
    check("rst_hit", 32'(bif.hit), 32'd0);
    check("rst_game_over", 32'(go), 32'd0);
    rst_n = 1'b1;
    tick();

    // March: two shifts right, then descent at the right edge.
    $display("phase march");
    enable = 1'b1; start = 1'b1; tick(); start = 1'b0;
    check("start_clear", 32'(bif.clear), 32'd1);
    check("start_array", 32'(arr), 32'(20'b00101010101010101010));
    check("start_line", 32'(line), 32'd4);
    repeat (4) tick();
    check("step1_array", 32'(arr), 32'(20'b01010101010101010100));
    repeat (4) tick();
    check("step2_array", 32'(arr), 32'(20'b10101010101010101000));
    repeat (4) tick();
    check("edge_line", 32'(line), 32'd5);
    check("edge_array", 32'(arr), 32'(20'b10101010101010101000));

    // Asynchronous reset mid-run takes effect before the next edge.
    $display("phase async reset");
    repeat (2) tick();
    async_reset();
    check("async_rst_array", 32'(arr), 32'h0);
    check("async_rst_line", 32'(line), 32'd4);
    tick();
    rst_n = 1'b1;
    tick();

    // Held bullet over a live invader: exactly one hit; dead column: none.
    $display("phase bullet");
    enable = 1'b0; start = 1'b1; tick(); start = 1'b0;
    bif.bullet_x = 5'd3; bif.bullet_y = 4'd4; bif.bullet_flying = 1'b1;
    hits = 0;
    repeat (5) begin tick(); if (bif.hit) hits++; end
    check("one_hit", 32'(hits), 32'd1);
    check("bit3_cleared", 32'(arr[3]), 32'd0);
    bif.bullet_flying = 1'b0; tick();
    bif.bullet_x = 5'd2; bif.bullet_flying = 1'b1;
    hits = 0;
    repeat (3) begin tick(); if (bif.hit) hits++; end
    check("dead_col_no_hit", 32'(hits), 32'd0);
    bif.bullet_flying = 1'b0; tick();

    // Hit on the edge invader in the same cycle as a step: shift, no descent.
    $display("phase hit plus step");
    async_reset(); tick(); rst_n = 1'b1; tick();
    enable = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    repeat (3) tick();
    bif.bullet_x = 5'd19; bif.bullet_y = 4'd4; bif.bullet_flying = 1'b1;
    tick();
    bif.bullet_flying = 1'b0;
    check("edge_hit", 32'(bif.hit), 32'd1);
    check("edge_hit_array", 32'(arr), 32'(20'b01010101010101010000));
    check("edge_hit_line", 32'(line), 32'd4);

    // Shoot every remaining invader; the last hit coincides with wave_cleared.
    $display("phase wave clear");
    enable = 1'b0; tick();
    done = 0;
    for (int k = 0; k < 25 && !done; k++) begin
      c = 0;
      for (int j = 19; j >= 0; j--) if (m_arr[j]) c = j;
      last = ($countones(m_arr) == 1);
      bif.bullet_x = 5'(c); bif.bullet_y = 4'(m_line); bif.bullet_flying = 1'b1;
      tick();
      if (last) begin
        check("last_hit", 32'(bif.hit), 32'd1);
        check("last_wave_cleared", 32'(wc), 32'd1);
      end
      bif.bullet_flying = 1'b0;
      tick();
      if (last) begin
        check("reload_array", 32'(arr), 32'(20'b00101010101010101010));
        check("reload_line", 32'(line), 32'd4);
        done = 1;
      end
    end
    check("wave_done", 32'(done), 32'd1);

    // March down to the landing row.
    $display("phase game over");
    enable = 1'b1;
    cyc = 0;
    while (!go && cyc < 5000) begin tick(); cyc++; end
    check("reach_game_over", 32'(go), 32'd1);
    check("land_line", 32'(line), 32'd14);
    snap = m_arr;
    c = 0;
    for (int j = 19; j >= 0; j--) if (snap[j]) c = j;
    hits = 0;
    repeat (5) begin
      bif.bullet_x = 5'(c); bif.bullet_y = 4'd14; bif.bullet_flying = 1'b1;
      tick(); if (bif.hit) hits++;
      bif.bullet_flying = 1'b0;
      tick(); if (bif.hit) hits++;
    end
    check("over_no_hit", 32'(hits), 32'd0);
    check("over_frozen", 32'(arr), 32'(snap));
    start = 1'b1; tick(); start = 1'b0;
    check("restart_clear", 32'(bif.clear), 32'd1);
    check("restart_array", 32'(arr), 32'(20'b00101010101010101010));
    check("restart_game_over", 32'(go), 32'd0);

    // Random play against the model.
    $display("phase random");
    repeat (3000) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else rst_n = 1'b1;
      enable = ($urandom_range(0, 9) != 0);
      start  = ($urandom_range(0, 39) == 0);
      bif.bullet_flying = ($urandom_range(0, 2) != 0);
      bif.bullet_x = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 19))
                                                 : 5'($urandom_range(0, 31));
      bif.bullet_y = ($urandom_range(0, 1) != 0) ? 4'(m_line) : 4'($urandom_range(0, 15));
      tick();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/invaders_controller.md
Name: invaders_controller

Overview:
- Owns the invader formation and is the responder on the player bullet interface.
- Consumes bullet_x/bullet_y/bullet_flying from player and answers with a one-cycle hit pulse.
- Marches the formation left/right, descends it at the edges, and drives invaders_array/invaders_line to sprite_drawer.
- Sequences game state (idle, playing, wave reload, game over) and issues clear to player on start.

Parameters:
COLS, 20, formation width in grid columns; bit i of invaders_array = invader alive at column i
STEP_CYCLES, 6000000, clk_12MHz cycles per march step (0.5 s)
INIT_ARRAY, 20'b00101010101010101010, formation loaded on start and on wave reload
INIT_LINE, 5'd4, row loaded on start and on wave reload
LAND_LINE, 5'd14, row at which invaders have landed

Ports:
clk_12MHz  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
enable  in  1  march enable; when 0, step counter holds and formation freezes, hit detection stays live
start_debounced  in  1  one-cycle start pulse from player
bullet_x  in  5  bullet column
bullet_y  in  4  bullet row
bullet_flying  in  1  bullet valid
invaders_array  out  COLS  alive mask
invaders_line  out  5  formation row
hit  out  1  one-cycle pulse, bullet struck a live invader
clear  out  1  one-cycle pulse to player on game start
game_over  out  1  high while in GAME_OVER
wave_cleared  out  1  one-cycle pulse when the last invader dies

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE, invaders_array=0, invaders_line=INIT_LINE, dir=RIGHT.
  - step counter=0, hit_lock=0.
  - hit=clear=game_over=wave_cleared=0.
- States:
  - IDLE: start_debounced -> load INIT_ARRAY/INIT_LINE, dir=RIGHT, counter=0, clear=1 for one cycle -> PLAYING.
  - PLAYING: march and hit detection active.
  - PLAYING, invaders_array becomes 0 -> wave_cleared=1 for one cycle -> RELOAD.
  - PLAYING, descent makes invaders_line==LAND_LINE -> GAME_OVER.
  - RELOAD (one cycle): load INIT_ARRAY/INIT_LINE, dir=RIGHT, counter=0 -> PLAYING.
  - GAME_OVER: game_over=1, formation frozen; start_debounced -> same as IDLE start.
- Hit detection (PLAYING only, combinational compare, registered output):
  - Condition: bullet_flying && !hit_lock && bullet_y=={invaders_line[3:0]} && invaders_line[4]==0 && bullet_x<COLS && invaders_array[bullet_x].
  - Next cycle: hit=1, that bit cleared, hit_lock=1.
  - hit_lock clears when bullet_flying=0, so one bullet yields at most one hit.
  - bullet_x>=COLS never hits (no out-of-range indexing).
- March:
  - In PLAYING with enable=1, the counter increments; at STEP_CYCLES-1 it wraps to 0 and a step occurs.
  - Step with dir=RIGHT, bit COLS-1 clear: array shifts toward higher index by 1.
  - Step with dir=RIGHT, bit COLS-1 set: no shift; invaders_line+1; dir=LEFT.
  - LEFT is symmetric, using bit 0 and shifting toward lower index.
  - invaders_line saturates at 31.
- Simultaneous hit and step in one cycle:
  - Hit is evaluated against the pre-step array and position.
  - Next array = step(array & ~hitmask); edge test uses the post-clear array.
- A hit that kills the last invader: hit=1 and wave_cleared=1 in the same cycle; no step is applied.
- start_debounced during PLAYING is ignored.
- Reset asserted mid-step or mid-hit returns immediately to reset values; no pulse is left pending.

Decomposition:
- Shared package: state encoding (IDLE, PLAYING, RELOAD, GAME_OVER), dir encoding, COLS/LAND_LINE/INIT constants (also used by sprite_drawer).
- One natural sub-module: invaders_step_timer (parameterised counter with enable and sync clear, emits step pulse).

Test Plan:
- Reset low mid-run -> all outputs at reset values within the same cycle; after release, start pulse -> clear=1 one cycle, invaders_array=INIT_ARRAY, invaders_line=4.
- STEP_CYCLES=4, enable=1, start -> after 4 cycles array=INIT_ARRAY<<1; at edge (bit 19 set) next step -> line=5, dir LEFT, array unchanged.
- Bullet x=3, y=4, flying held 5 cycles over live invader -> exactly one hit pulse, bit 3 cleared; bullet x=2 (dead column) -> no hit.
- Hit and step in same cycle, bullet on bit 19 moving right -> bit 19 cleared, then shift right with no descent, line stays 4.
- Kill all invaders -> final hit coincides with wave_cleared; RELOAD next cycle restores INIT_ARRAY, line=4.
- Force descents until line=14 -> game_over=1, formation frozen, bullets give no hit; start -> clear pulse, replay.
